// File: rtl/interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : interval_timer
// Description : Programmable interval timer that counts CLOCK_50 cycles up to
//               a terminal value and emits a one-cycle tick (one-shot or
//               periodic) with a sticky expired flag. Define
//               INTERVAL_TIMER_PAUSE_EN to enable the PAUSED state.
// Revision    : 1.0 - initial release
// ============================================================================
module interval_timer #(
    parameter int          WIDTH        = 27,
    parameter int unsigned DEFAULT_TERM = 99_999_999
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic             pause,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             expired,
    output logic             busy
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_run    = 2'd1;
    localparam logic [1:0] c_paused = 2'd2;
    localparam logic [1:0] c_done   = 2'd3;

    localparam logic [WIDTH-1:0] c_default_term = WIDTH'(DEFAULT_TERM);
    localparam logic [WIDTH-1:0] c_one          = WIDTH'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_term;
    logic             r_mode;
    logic             r_tick;
    logic             r_expired;
    logic             w_pause;
    logic             w_active;
    logic             w_at_term;
    logic             w_fire;
    logic             w_busy;

`ifdef INTERVAL_TIMER_PAUSE_EN
    assign w_pause = pause;
`else
    logic w_unused_pause;
    assign w_unused_pause = pause;
    assign w_pause        = 1'b0;
`endif

    assign w_active  = (r_state == c_run) || (r_state == c_paused);
    assign w_at_term = (r_count >= r_term);
    // stop/start pre-empt a completing interval, so no tick for an aborted one
    assign w_fire    = w_active && !w_pause && !stop && !start && w_at_term;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (stop) begin
            w_state_next = c_idle;
        end else if (start) begin
            w_state_next = c_run;
        end else begin
            case (r_state)
                c_run, c_paused: begin
                    if (w_pause) begin
                        w_state_next = c_paused;
                    end else if (w_at_term) begin
                        w_state_next = r_mode ? c_run : c_done;
                    end else begin
                        w_state_next = c_run;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_busy = 1'b0;
        if ((r_state == c_run) || (r_state == c_paused)) begin
            w_busy = 1'b1;
        end
    end

    // Leaving PAUSED counts normally, so each paused cycle costs exactly one cycle
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (stop || start) begin
            r_count <= '0;
        end else if (w_active) begin
            if (!w_pause) begin
                r_count <= w_at_term ? '0 : (r_count + c_one);
            end
        end else begin
            r_count <= '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_mode <= 1'b0;
        end else if (start && !stop) begin
            r_mode <= periodic;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_term <= c_default_term;
        end else if (load_en) begin
            r_term <= load_val;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_fire;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_expired <= 1'b0;
        end else if (w_fire) begin
            r_expired <= 1'b1;
        end else if (ack) begin
            r_expired <= 1'b0;
        end
    end

    assign count   = r_count;
    assign tick    = r_tick;
    assign expired = r_expired;
    assign busy    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_interval_timer
// Description : Scoreboard bench for interval_timer (WIDTH=8, DEFAULT_TERM=9).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interval_timer;

    logic       CLOCK_50;
    logic       resetn;
    logic       start;
    logic       stop;
    logic       periodic;
    logic       load_en;
    logic [7:0] load_val;
    logic       pause;
    logic       ack;
    logic [7:0] count;
    logic       tick;
    logic       expired;
    logic       busy;

    interval_timer #(
        .WIDTH        (8),
        .DEFAULT_TERM (9)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .load_en  (load_en),
        .load_val (load_val),
        .pause    (pause),
        .ack      (ack),
        .count    (count),
        .tick     (tick),
        .expired  (expired),
        .busy     (busy)
    );

    typedef struct {
        logic [31:0] id;
        logic [31:0] cyc;
        logic [31:0] count;
        logic [31:0] tick;
        logic [31:0] busy;
        logic [31:0] expired;
    } snap_t;

    snap_t sq[$];
    int    tq[$];
    int    cyc;
    int    vectors;
    int    miscompares;

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    initial cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic exp_snap(input int id, input int c, input int cnt,
                            input int t, input int b, input int e);
        snap_t s;
        s.id      = id;
        s.cyc     = c;
        s.count   = cnt;
        s.tick    = t;
        s.busy    = b;
        s.expired = e;
        sq.push_back(s);
        if (t != 0) tq.push_back(c);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge CLOCK_50);
    endtask

    task automatic start_pulse(input logic p);
        periodic = p;
        start    = 1'b1;
        @(negedge CLOCK_50);
        start    = 1'b0;
    endtask

    task automatic ack_pulse(input int id);
        ack = 1'b1;
        exp_snap(id, cyc + 1, 0, 0, 0, 0);
        @(negedge CLOCK_50);
        ack = 1'b0;
    endtask

    task automatic load(input logic [7:0] v);
        load_en  = 1'b1;
        load_val = v;
        @(negedge CLOCK_50);
        load_en  = 1'b0;
    endtask

    // Monitor: full-state snapshots plus an independent tick scoreboard
    always @(negedge CLOCK_50) begin
        snap_t s;
        while (sq.size() > 0 && int'(sq[0].cyc) <= cyc) begin
            s = sq.pop_front();
            vectors++;
            if (int'(s.cyc) != cyc) begin
                miscompares++;
                $display("FAIL snap_missed id=%0d cyc=%0d seen at cyc=%0d", s.id, s.cyc, cyc);
            end else if ({24'd0, count} !== s.count || {31'd0, tick} !== s.tick ||
                         {31'd0, busy} !== s.busy || {31'd0, expired} !== s.expired) begin
                miscompares++;
                $display("FAIL snap id=%0d cyc=%0d: got count=%0d tick=%b busy=%b expired=%b, want count=%0d tick=%0d busy=%0d expired=%0d",
                         s.id, cyc, count, tick, busy, expired, s.count, s.tick, s.busy, s.expired);
            end
        end
        if (tick === 1'b1) begin
            vectors++;
            if (tq.size() > 0 && tq[0] == cyc) begin
                void'(tq.pop_front());
            end else begin
                miscompares++;
                $display("FAIL tick_unexpected cyc=%0d: got tick=1, want tick=0", cyc);
            end
        end
        while (tq.size() > 0 && tq[0] < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL tick_missed: want tick=1 at cyc=%0d, got none", tq[0]);
            void'(tq.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int k;
        vectors     = 0;
        miscompares = 0;
        resetn   = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        periodic = 1'b0;
        load_en  = 1'b0;
        load_val = 8'd0;
        pause    = 1'b0;
        ack      = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        exp_snap(0, cyc + 1, 0, 0, 0, 0);
        exp_snap(0, cyc + 2, 0, 0, 0, 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);

        // One-shot with default term 9: tick 10 cycles after start
        k = cyc + 1;
        for (int n = 0; n <= 9; n++) exp_snap(1, k + n, n, 0, 1, 0);
        exp_snap(1, k + 10, 0, 1, 0, 1);
        exp_snap(1, k + 11, 0, 0, 0, 1);
        start_pulse(1'b0);
        wait_to(k + 12);
        ack_pulse(1);

        // Periodic with term 3
        load(8'd3);
        k = cyc + 1;
        for (int n = 0; n <= 20; n++)
            exp_snap(2, k + n, n % 4, (n > 0 && n % 4 == 0) ? 1 : 0, 1, (n >= 4) ? 1 : 0);
        start_pulse(1'b1);
        wait_to(k + 20);
        stop = 1'b1;
        exp_snap(2, k + 21, 0, 0, 0, 1);
        @(negedge CLOCK_50);
        stop = 1'b0;
        ack_pulse(2);

        // term 0 periodic: tick every cycle; ack coinciding with a tick loses
        load(8'd0);
        k = cyc + 1;
        exp_snap(3, k, 0, 0, 1, 0);
        for (int n = 1; n <= 5; n++) exp_snap(3, k + n, 0, 1, 1, 1);
        start_pulse(1'b1);
        wait_to(k + 2);
        ack = 1'b1;
        @(negedge CLOCK_50);
        ack = 1'b0;
        wait_to(k + 5);
        stop = 1'b1;
        exp_snap(3, k + 6, 0, 0, 0, 1);
        @(negedge CLOCK_50);
        stop = 1'b0;
        ack_pulse(3);

        // Restart at count 5
        load(8'd9);
        k = cyc + 1;
        for (int n = 0; n <= 5; n++) exp_snap(4, k + n, n, 0, 1, 0);
        for (int n = 0; n <= 9; n++) exp_snap(4, k + 6 + n, n, 0, 1, 0);
        exp_snap(4, k + 16, 0, 1, 0, 1);
        start_pulse(1'b0);
        wait_to(k + 5);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        wait_to(k + 16);
        ack_pulse(4);

        // Stop at count 5
        k = cyc + 1;
        for (int n = 0; n <= 5; n++) exp_snap(5, k + n, n, 0, 1, 0);
        for (int n = 6; n <= 16; n++) exp_snap(5, k + n, 0, 0, 0, 0);
        start_pulse(1'b0);
        wait_to(k + 5);
        stop = 1'b1;
        @(negedge CLOCK_50);
        stop = 1'b0;
        wait_to(k + 16);

        // Lower term below count at count 5: tick on the next cycle
        k = cyc + 1;
        for (int n = 0; n <= 6; n++) exp_snap(6, k + n, n, 0, 1, 0);
        exp_snap(6, k + 7, 0, 1, 0, 1);
        exp_snap(6, k + 8, 0, 0, 0, 1);
        start_pulse(1'b0);
        wait_to(k + 5);
        load_en  = 1'b1;
        load_val = 8'd2;
        @(negedge CLOCK_50);
        load_en  = 1'b0;
        wait_to(k + 8);
        ack_pulse(6);
        load(8'd9);

        // Pause for 5 cycles at count 4
        k = cyc + 1;
`ifdef INTERVAL_TIMER_PAUSE_EN
        for (int n = 0; n <= 4; n++)   exp_snap(7, k + n, n, 0, 1, 0);
        for (int n = 5; n <= 9; n++)   exp_snap(7, k + n, 4, 0, 1, 0);
        for (int n = 10; n <= 14; n++) exp_snap(7, k + n, n - 5, 0, 1, 0);
        exp_snap(7, k + 15, 0, 1, 0, 1);
        exp_snap(7, k + 16, 0, 0, 0, 1);
`else
        for (int n = 0; n <= 9; n++)   exp_snap(7, k + n, n, 0, 1, 0);
        exp_snap(7, k + 10, 0, 1, 0, 1);
        for (int n = 11; n <= 16; n++) exp_snap(7, k + n, 0, 0, 0, 1);
`endif
        start_pulse(1'b0);
        wait_to(k + 4);
        pause = 1'b1;
        wait_to(k + 9);
        pause = 1'b0;
        wait_to(k + 16);

        // Reset mid-interval in periodic mode with expired still set
        load(8'd12);
        k = cyc + 1;
        for (int n = 0; n <= 7; n++) exp_snap(8, k + n, n, 0, 1, 1);
        exp_snap(8, k + 8, 0, 0, 0, 0);
        start_pulse(1'b1);
        wait_to(k + 7);
        resetn = 1'b0;
        @(negedge CLOCK_50);
        resetn = 1'b1;

        // term must be back to DEFAULT_TERM (9)
        k = cyc + 1;
        for (int n = 0; n <= 9; n++) exp_snap(9, k + n, n, 0, 1, 0);
        exp_snap(9, k + 10, 0, 1, 0, 1);
        exp_snap(9, k + 11, 0, 0, 0, 1);
        start_pulse(1'b0);
        wait_to(k + 14);

        #5;
        while (sq.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL snap_unchecked id=%0d cyc=%0d never sampled", sq[0].id, sq[0].cyc);
            void'(sq.pop_front());
        end
        while (tq.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL tick_missed: want tick=1 at cyc=%0d, got none", tq[0]);
            void'(tq.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interval_timer.md
# interval_timer

Parametrised interval timer for the game datapath, replacing fixed-interval delay counters. Counts CLOCK_50 cycles up to a programmable terminal value and issues a one-cycle `tick`, in one-shot or periodic mode, with a sticky `expired` flag that the FSM clears via `ack`. Used for frame pacing (1/60 s), input debounce and multi-second game delays. A single instance replaces each hard-coded counter.

## Interface
- `WIDTH`, 27: counter and terminal width in bits.
- `DEFAULT_TERM`, 99_999_999: terminal value after reset; the interval is `DEFAULT_TERM + 1` cycles, which is 2 s at 50 MHz.

Ports (clock and reset first):
- `CLOCK_50`  in  1: clock.
- `resetn`  in  1: reset, synchronous, active-low; clock CLOCK_50.
- `start`  in  1: begin or restart timing from count 0.
- `stop`  in  1: abort and return to IDLE.
- `periodic`  in  1: sampled on accepted `start`; 1 = auto-reload, 0 = one-shot.
- `load_en`  in  1: write `load_val` into the terminal register.
- `load_val`  in  WIDTH: new terminal value.
- `pause`  in  1: hold count; active only with the macro (see Configuration).
- `ack`  in  1: clear `expired`.
- `count`  out  WIDTH: current count.
- `tick`  out  1: one-cycle pulse when an interval completes.
- `expired`  out  1: sticky; set by `tick`, cleared by `ack`.
- `busy`  out  1: 1 in RUN or PAUSED.

## Operation
- Registers: `state`, `count`, `term`, `mode`, `tick`, `expired`. All are updated on the rising edge of CLOCK_50.
- Reset values when `resetn = 0`: state=IDLE, count=0, term=DEFAULT_TERM, mode=0, tick=0, expired=0, busy=0.
- Priority per edge: resetn > stop > start > pause > count/terminal logic.
- States:
  - IDLE: count held at 0. On `start`, go to RUN with count=0 and mode=periodic.
  - RUN: if count >= term, then tick<=1 and count<=0; the next state is RUN if mode=1, else DONE. Otherwise count<=count+1.
  - PAUSED (macro only): count frozen, no tick. Returns to RUN when `pause` falls.
  - DONE: count=0, busy=0. On `start`, go to RUN. `expired` persists until `ack`.
- `stop` in any state: go to IDLE, count=0, tick=0. `expired` is unchanged.
- `start` while in RUN or PAUSED: restart at count=0 and resample `periodic`. No tick is issued for the aborted interval.
- `load_en` is accepted in every state and takes effect at the next compare. The compare uses `>=`, so lowering `term` below the current count fires on the next cycle.
- `term = 0`: periodic mode ticks every cycle; one-shot ticks 1 cycle after start.
- `tick` and `ack` on the same edge: `expired` stays 1 (set wins).
- Count arithmetic is unsigned modulo 2^WIDTH. It cannot wrap, because the reload occurs at `term <= 2^WIDTH-1`.
- `busy = (state==RUN) || (state==PAUSED)`. This is combinational from `state`.

## Timing
- If `start` is sampled at edge k, count=0 and busy=1 after edge k. count=n after edge k+n.
- The first `tick` is high for exactly the cycle after edge k+term+1, giving a latency of term+1 cycles.
- Periodic ticks are spaced exactly term+1 cycles apart.
- `expired` rises on the same edge as `tick` and falls on the edge that samples `ack` (when no simultaneous tick).
- One-shot: busy falls on the same edge that raises `tick`.
- Pause (macro on): each paused cycle adds exactly one cycle to the interval.
- `resetn` low mid-interval: all outputs are at reset values after that edge, and no tick is issued.

## Configuration
- `INTERVAL_TIMER_PAUSE_EN` defined: PAUSED state is present. `pause=1` in RUN enters PAUSED on the next edge, and `pause=0` returns to RUN.
- `INTERVAL_TIMER_PAUSE_EN` undefined: the `pause` port exists but is ignored, PAUSED is unreachable and synthesised out, and behaviour is otherwise identical.

## Test plan
- Reset, then `start` with periodic=0 and the default `term`. Use WIDTH=8, DEFAULT_TERM=9 for the bench. Expected: tick high exactly 10 cycles after start, busy falls at the same edge, expired=1 until ack.
- Load `term=3`, start with periodic=1, run 20 cycles. Expected: ticks at 4, 8, 12, 16, 20 cycles, count sequence 0,1,2,3,0 repeating.
- Load `term=0`, periodic=1. Expected: tick high every cycle, count stays 0. Assert `ack` on a tick edge: expired stays 1.
- Start with term=9, then at count=5 do one of the following:
  - Assert start again: expect count=0 and the next tick 10 cycles later.
  - Assert stop: expect IDLE, no tick, busy=0.
  - Load term=2: expect a tick on the next cycle.
- Macro on, term=9: pause for 5 cycles at count=4. Expected: count frozen at 4 and the tick delayed by exactly 5 cycles. Macro off, same stimulus: tick at the normal time.
- Drive resetn low at count=7 in periodic mode. Expected: count=0, tick=0, expired=0, busy=0, term back to DEFAULT_TERM.
